pll_clock_manager: RTL and testbench
====================================

# pll_clock_manager

Parametrised PLL supervisor and clock-enable generator sitting directly behind the SB_PLL40_CORE instance in each design. It synchronises and qualifies the PLL lock signal, and holds a design-wide synchronous reset until lock has been stable. It generates NUM_EN fractional-rate clock-enable strobes from the single PLL output clock using phase accumulators. This replaces per-frequency PLL instances for low-rate logic, and it counts lock-loss events for debug.

## Interface
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before `locked` asserts; minimum 1.
- RESET_HOLD_CYCLES, 16: cycles `reset_out_n` stays low after `locked` asserts; minimum 1.
- NUM_EN, 2: number of clock-enable outputs; minimum 1.
- ACC_WIDTH, 16: phase accumulator width, 2 to 32.
- INCS, {16'h8000, 16'h4000}: packed NUM_EN×ACC_WIDTH increments, unsigned.
  - Channel i uses INCS[i*ACC_WIDTH +: ACC_WIDTH].
  - Strobe rate = f_clock × INC / 2^ACC_WIDTH.
- LOSS_CNT_WIDTH, 8: width of the lock-loss counter.

Ports:
- clock_in  input  1  PLL output clock (PLLOUTCORE); the only clock.
- resetn  input  1  asynchronous, active-low reset.
- pll_locked  input  1  raw LOCK from the PLL; asynchronous to clock_in.
- locked  output  1  qualified lock.
- reset_out_n  output  1  synchronous active-low reset for downstream logic.
- clk_en  output  NUM_EN  single-cycle enable strobes.
- loss_count  output  LOSS_CNT_WIDTH  saturating count of lock losses after RUN was reached.

## Operation
- pll_locked passes through a 2-flop synchroniser (lk_s), both flops reset to 0.
- FSM states: WAIT, STABLE, HOLD, RUN. Reset state is WAIT.
  - WAIT: counter cleared. Goes to STABLE when lk_s=1.
  - STABLE: counter increments each cycle with lk_s=1. Goes to HOLD when counter reaches LOCK_STABLE_CYCLES-1 with lk_s=1; counter clears.
  - HOLD: counter increments. Goes to RUN at RESET_HOLD_CYCLES-1.
  - RUN: steady state.
- In STABLE, HOLD or RUN, lk_s=0 sends the FSM to WAIT and clears the counter.
  - Loss has priority over any simultaneous count-complete transition.
  - loss_count increments, saturating at all-ones, only on the RUN→WAIT transition.
- All outputs are registered and derived from the next state:
  - locked = 1 in HOLD and RUN.
  - reset_out_n = 1 in RUN only.
- Phase accumulator acc[i], ACC_WIDTH bits:
  - In RUN: acc[i] <= acc[i] + INC[i] mod 2^ACC_WIDTH, and clk_en[i] <= carry-out of that add.
  - In any other state: acc[i] <= 0 and clk_en[i] <= 0.
  - INC=0 never strobes. INC=2^(ACC_WIDTH-1) strobes every 2nd cycle.
  - Strobe spacing varies by at most 1 cycle (floor/ceil of 2^W/INC).
- Reset values on assertion of resetn: state WAIT, all counters and accumulators 0, locked=0, reset_out_n=0, clk_en=0, loss_count=0.
- resetn asserted mid-RUN clears everything immediately (asynchronously). A reset is not counted as a lock loss.

## Timing
- Lock acquisition, with pll_locked first sampled high at edge 0:
  - lk_s=1 after edge 1.
  - locked rises after edge 1+LOCK_STABLE_CYCLES.
  - reset_out_n rises RESET_HOLD_CYCLES edges later.
- First possible clk_en pulse: the 2nd RUN edge for INC ≤ 2^(ACC_WIDTH-1). The first RUN edge strobes only if INC would carry from 0, which is impossible.
- Lock loss, with pll_locked sampled low at edge n:
  - locked, reset_out_n and clk_en all fall after edge n+2.
  - loss_count updates on the same edge.
- A pll_locked glitch shorter than 1 cycle may be missed. A glitch of ≥2 cycles during STABLE restarts the stability count from zero.
- All outputs change only on rising clock_in edges, except on resetn assertion.

## Test plan
- Acquisition: LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4, pll_locked high before edge 0 -> locked=1 after edge 9, reset_out_n=1 after edge 13, loss_count=0.
- Glitch in STABLE: pll_locked low for 3 cycles after 5 stable cycles -> FSM back to WAIT; locked rises 1+8 edges after lock is re-sampled; loss_count stays 0.
- Rates: INCS={16'h8000,16'h4000} in RUN for 64 cycles -> clk_en[1] pulses 32 times, every 2nd cycle; clk_en[0] pulses 16 times, every 4th cycle; each pulse 1 cycle wide.
- Fractional: INC=16'h5555 over 3×2^16 RUN cycles -> exactly 65535 pulses; spacing only 3 or 4 cycles.
- Loss in RUN: drop pll_locked for 2 cycles, 300 times -> loss_count = 255 (saturated); each drop forces locked=0, reset_out_n=0 and clk_en=0 two edges after sampling.
- Async reset mid-RUN: assert resetn between edges -> all outputs 0 immediately, loss_count=0; release then re-acquires as in the first scenario.

Source files
------------

// File: rtl/pll_clock_manager.sv
// rtl/pll_clock_manager.sv - PLL lock supervisor, reset sequencer and fractional clock-enable generator
module pll_clock_manager #(
    parameter int unsigned                 LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned                 RESET_HOLD_CYCLES  = 16,
    parameter int unsigned                 NUM_EN             = 2,
    parameter int unsigned                 ACC_WIDTH          = 16,
    parameter logic [NUM_EN*ACC_WIDTH-1:0] INCS               = {16'h8000, 16'h4000},
    parameter int unsigned                 LOSS_CNT_WIDTH     = 8
) (
    input  logic                      clock_in,
    input  logic                      resetn,
    input  logic                      pll_locked,
    output logic                      locked,
    output logic                      reset_out_n,
    output logic [NUM_EN-1:0]         clk_en,
    output logic [LOSS_CNT_WIDTH-1:0] loss_count
);
    localparam int unsigned CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                      LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {S_WAIT, S_STABLE, S_HOLD, S_RUN} state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             lk_meta;
    logic             lk_s;
    logic             lost;

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;
        end
    end

    // The WAIT->STABLE edge already counts as the first stable cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        lost     = 1'b0;
        case (state)
            S_WAIT: begin
                cnt_nx = '0;
                if (lk_s) begin
                    if (LOCK_STABLE_CYCLES == 1) begin
                        state_nx = S_HOLD;
                    end else begin
                        state_nx = S_STABLE;
                        cnt_nx   = CNT_W'(1);
                    end
                end
            end
            S_STABLE: begin
                if (cnt == STABLE_LAST) begin
                    state_nx = S_HOLD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_RUN:   state_nx = S_RUN;
            default: state_nx = S_WAIT;
        endcase
        if (state != S_WAIT && !lk_s) begin
            state_nx = S_WAIT;
            cnt_nx   = '0;
            lost     = (state == S_RUN);
        end
    end

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            state       <= S_WAIT;
            cnt         <= '0;
            locked      <= 1'b0;
            reset_out_n <= 1'b0;
            loss_count  <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            locked      <= (state_nx == S_HOLD) || (state_nx == S_RUN);
            reset_out_n <= (state_nx == S_RUN);
            if (lost && (loss_count != '1)) begin
                loss_count <= loss_count + LOSS_CNT_WIDTH'(1);
            end
        end
    end

    // Strobe is the carry-out of each accumulator step while running.
    for (genvar i = 0; i < NUM_EN; i++) begin : g_en
        localparam logic [ACC_WIDTH-1:0] INC = INCS[i*ACC_WIDTH +: ACC_WIDTH];
        logic [ACC_WIDTH-1:0] acc;
        logic [ACC_WIDTH:0]   sum;
        logic                 strobe;

        assign sum       = {1'b0, acc} + {1'b0, INC};
        assign clk_en[i] = strobe;

        always_ff @(posedge clock_in or negedge resetn) begin
            if (!resetn) begin
                acc    <= '0;
                strobe <= 1'b0;
            end else if (state_nx == S_RUN) begin
                acc    <= sum[ACC_WIDTH-1:0];
                strobe <= sum[ACC_WIDTH];
            end else begin
                acc    <= '0;
                strobe <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pll_clock_manager.sv
// tb/tb_pll_clock_manager.sv - self-checking bench for pll_clock_manager
module tb_pll_clock_manager;
    localparam int L = 8;
    localparam int R = 4;
    localparam int W = 16;
    localparam int N = 4;
    localparam logic [N*W-1:0] INCS = {16'h0000, 16'h5555, 16'h8000, 16'h4000};

    logic         clock_in = 1'b0;
    logic         resetn;
    logic         pll_locked;
    logic         locked;
    logic         reset_out_n;
    logic [N-1:0] clk_en;
    logic [7:0]   loss_count;

    always #5 clock_in = ~clock_in;

    pll_clock_manager #(
        .LOCK_STABLE_CYCLES(L),
        .RESET_HOLD_CYCLES (R),
        .NUM_EN            (N),
        .ACC_WIDTH         (W),
        .INCS              (INCS),
        .LOSS_CNT_WIDTH    (8)
    ) dut (
        .clock_in   (clock_in),
        .resetn     (resetn),
        .pll_locked (pll_locked),
        .locked     (locked),
        .reset_out_n(reset_out_n),
        .clk_en     (clk_en),
        .loss_count (loss_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: outputs follow from the length of the current run of
    // synchronised-high lock samples (streak).
    longint       inc_tab [N] = '{64'h4000, 64'h8000, 64'h5555, 64'h0000};
    longint       streak;
    bit           ms1, ms2;
    logic [7:0]   exp_loss;
    logic         exp_locked, exp_rstn;
    logic [N-1:0] exp_en;

    task automatic model_reset();
        streak = 0; ms1 = 0; ms2 = 0;
        exp_loss = 0; exp_locked = 0; exp_rstn = 0; exp_en = '0;
    endtask

    task automatic cycle(input bit v);
        bit     lk;
        longint k;
        pll_locked = v;
        @(posedge clock_in);
        lk = ms2; ms2 = ms1; ms1 = v;
        if (lk) begin
            streak++;
        end else begin
            if (streak >= L + R && exp_loss != 8'hFF) exp_loss++;
            streak = 0;
        end
        exp_locked = (streak >= L);
        exp_rstn   = (streak >= L + R);
        k = streak - (L + R) + 1;
        for (int i = 0; i < N; i++) begin
            if (exp_rstn)
                exp_en[i] = ((k * inc_tab[i]) >> W) != (((k - 1) * inc_tab[i]) >> W);
            else
                exp_en[i] = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        resetn = 0; pll_locked = 0; model_reset();
        repeat (3) @(posedge clock_in);
        #1;
        n_checks++; if (locked !== 1'b0) $display("FAIL reset_locked got %b want 0", locked); else n_pass++;
        n_checks++; if (reset_out_n !== 1'b0) $display("FAIL reset_rstn got %b want 0", reset_out_n); else n_pass++;
        n_checks++; if (clk_en !== '0) $display("FAIL reset_clk_en got %b want 0", clk_en); else n_pass++;
        n_checks++; if (loss_count !== 8'd0) $display("FAIL reset_loss got %0d want 0", loss_count); else n_pass++;
        #2 resetn = 1;
    endtask

    task automatic test_acquisition();
        for (int e = 0; e < 20; e++) begin
            cycle(1);
            n_checks++;
            if ({locked, reset_out_n, clk_en, loss_count} !== {exp_locked, exp_rstn, exp_en, exp_loss})
                $display("FAIL acq_e%0d got l=%b r=%b en=%b loss=%0d want l=%b r=%b en=%b loss=%0d",
                         e, locked, reset_out_n, clk_en, loss_count, exp_locked, exp_rstn, exp_en, exp_loss);
            else n_pass++;
            if (e == 8 || e == 9) begin
                n_checks++;
                if (locked !== (e == 9)) $display("FAIL acq_locked_e%0d got %b want %b", e, locked, e == 9);
                else n_pass++;
            end
            if (e == 12 || e == 13) begin
                n_checks++;
                if (reset_out_n !== (e == 13)) $display("FAIL acq_rstn_e%0d got %b want %b", e, reset_out_n, e == 13);
                else n_pass++;
            end
        end
        n_checks++; if (loss_count !== 8'd0) $display("FAIL acq_loss got %0d want 0", loss_count); else n_pass++;
    endtask

    task automatic test_glitch_stable();
        for (int j = 0; j < 26; j++) begin
            cycle((j < 7) || (j >= 10));
            n_checks++;
            if ({locked, reset_out_n, clk_en, loss_count} !== {exp_locked, exp_rstn, exp_en, exp_loss})
                $display("FAIL glitch_j%0d got l=%b r=%b en=%b loss=%0d want l=%b r=%b en=%b loss=%0d",
                         j, locked, reset_out_n, clk_en, loss_count, exp_locked, exp_rstn, exp_en, exp_loss);
            else n_pass++;
            if (j >= 10) begin
                n_checks++;
                if (locked !== (j >= 19)) $display("FAIL glitch_locked_j%0d got %b want %b", j, locked, j >= 19);
                else n_pass++;
            end
        end
        n_checks++; if (loss_count !== 8'd0) $display("FAIL glitch_loss got %0d want 0", loss_count); else n_pass++;
    endtask

    task automatic test_rates();
        int c0 = 0, c1 = 0, c3 = 0;
        for (int n = 0; n < 64; n++) begin
            cycle(1);
            n_checks++;
            if ({locked, reset_out_n, clk_en, loss_count} !== {exp_locked, exp_rstn, exp_en, exp_loss})
                $display("FAIL rates_n%0d got en=%b want en=%b", n, clk_en, exp_en);
            else n_pass++;
            c0 += int'(clk_en[0]); c1 += int'(clk_en[1]); c3 += int'(clk_en[3]);
        end
        n_checks++; if (c0 != 16) $display("FAIL rates_ch0 got %0d pulses want 16", c0); else n_pass++;
        n_checks++; if (c1 != 32) $display("FAIL rates_ch1 got %0d pulses want 32", c1); else n_pass++;
        n_checks++; if (c3 != 0) $display("FAIL rates_ch3 got %0d pulses want 0", c3); else n_pass++;
    endtask

    task automatic test_fractional();
        int cnt = 0, exp_cnt = 0, bad = 0, last = -1;
        for (int n = 0; n < 12288; n++) begin
            cycle(1);
            n_checks++;
            if ({locked, reset_out_n, clk_en, loss_count} !== {exp_locked, exp_rstn, exp_en, exp_loss})
                $display("FAIL frac_n%0d got en=%b want en=%b", n, clk_en, exp_en);
            else n_pass++;
            exp_cnt += int'(exp_en[2]);
            if (clk_en[2]) begin
                cnt++;
                if (last >= 0 && (n - last < 3 || n - last > 4)) bad++;
                last = n;
            end
        end
        n_checks++; if (cnt != exp_cnt) $display("FAIL frac_count got %0d want %0d", cnt, exp_cnt); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL frac_spacing got %0d bad gaps want 0", bad); else n_pass++;
    endtask

    task automatic test_loss_run();
        for (int d = 0; d < 300; d++) begin
            int extra = int'($urandom_range(0, 5));
            for (int c = -2; c < L + R + 2 + extra; c++) begin
                cycle(c >= 0);
                n_checks++;
                if ({locked, reset_out_n, clk_en, loss_count} !== {exp_locked, exp_rstn, exp_en, exp_loss})
                    $display("FAIL loss_d%0d_c%0d got l=%b r=%b en=%b loss=%0d want l=%b r=%b en=%b loss=%0d",
                             d, c, locked, reset_out_n, clk_en, loss_count, exp_locked, exp_rstn, exp_en, exp_loss);
                else n_pass++;
                if (c == 0) begin
                    n_checks++;
                    if ({locked, reset_out_n, clk_en} !== '0)
                        $display("FAIL loss_drop_d%0d got l=%b r=%b en=%b want all 0", d, locked, reset_out_n, clk_en);
                    else n_pass++;
                end
            end
        end
        n_checks++; if (loss_count !== 8'hFF) $display("FAIL loss_saturate got %0d want 255", loss_count); else n_pass++;
    endtask

    task automatic test_async_reset();
        @(posedge clock_in);
        #4 resetn = 0;
        #1;
        n_checks++; if (locked !== 1'b0) $display("FAIL areset_locked got %b want 0", locked); else n_pass++;
        n_checks++; if (reset_out_n !== 1'b0) $display("FAIL areset_rstn got %b want 0", reset_out_n); else n_pass++;
        n_checks++; if (clk_en !== '0) $display("FAIL areset_clk_en got %b want 0", clk_en); else n_pass++;
        n_checks++; if (loss_count !== 8'd0) $display("FAIL areset_loss got %0d want 0", loss_count); else n_pass++;
        model_reset();
        repeat (2) @(posedge clock_in);
        #3 resetn = 1;
        test_acquisition();
    endtask

    initial begin
        resetn = 0;
        pll_locked = 0;
        test_reset();
        test_glitch_stable();
        test_reset();
        test_acquisition();
        test_rates();
        test_fractional();
        test_loss_run();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
